nexys_starship_game_ctrl: RTL and testbench

Parametrised top-level game controller for Nexys Starship. It supersedes the three-state INIT/PLAY/GAMEOVER sequencer and adds pause, multi-level progression with a timed level-up banner, a lives counter, a score counter, a win state and restart-without-reset. It sits between the board buttons and the gameplay and VGA blocks. It supplies mode flags and counters to both.

---
 rtl/nexys_starship_game_ctrl.sv | 160 ++++++++++++++++
 tb/tb_nexys_starship_game_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nexys_starship_game_ctrl.sv
// ==========================================================================
// nexys_starship_game_ctrl: Nexys Starship game-mode sequencer with lives, levels and score
// Rev 1.0
// ==========================================================================
`default_nettype none

module nexys_starship_game_ctrl #(
    parameter int LIVES         = 3,
    parameter int LEVELS        = 4,
    parameter int LEVEL_PTS     = 16,
    parameter int SCORE_W       = 12,
    parameter int BANNER_CYCLES = 100000000
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               BtnU,
    input  logic               BtnC,
    input  logic               hit,
    input  logic               score_inc,
    output logic               q_Init,
    output logic               q_Play,
    output logic               q_Pause,
    output logic               q_LevelUp,
    output logic               q_GameOver,
    output logic               q_Win,
    output logic               play_flag,
    output logic [3:0]         lives,
    output logic [3:0]         level,
    output logic [SCORE_W-1:0] score
);

    localparam int PTS_W = $clog2(LEVEL_PTS + 1);
    localparam int BAN_W = $clog2(BANNER_CYCLES + 1);
    localparam logic [PTS_W-1:0]   PTS_LAST   = PTS_W'(LEVEL_PTS - 1);
    localparam logic [BAN_W-1:0]   BAN_LAST   = BAN_W'(BANNER_CYCLES - 1);
    localparam logic [3:0]         LIVES_INIT = 4'(LIVES);
    localparam logic [3:0]         LEVEL_LAST = 4'(LEVELS - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

    typedef enum logic [5:0] {
        S_INIT  = 6'b000001,
        S_PLAY  = 6'b000010,
        S_PAUSE = 6'b000100,
        S_LVLUP = 6'b001000,
        S_OVER  = 6'b010000,
        S_WIN   = 6'b100000
    } state_t;

    state_t             state_q;
    logic [3:0]         lives_q;
    logic [3:0]         level_q;
    logic [SCORE_W-1:0] score_q;
    logic [PTS_W-1:0]   pts_q;
    logic [BAN_W-1:0]   banner_q;
    logic               btnu_prev_q, btnc_prev_q;
    logic               btnu_arm_q, btnc_arm_q;

    logic               btnu_rise, btnc_rise, pts_wrap;
    logic [SCORE_W-1:0] score_sat;

    // The arm bits keep a button held through reset from firing until it has been seen released.
    assign btnu_rise = BtnU & ~btnu_prev_q & btnu_arm_q;
    assign btnc_rise = BtnC & ~btnc_prev_q & btnc_arm_q;
    assign score_sat = (score_q == SCORE_MAX) ? score_q : score_q + SCORE_W'(1);
    assign pts_wrap  = (pts_q == PTS_LAST);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_INIT;
            lives_q     <= LIVES_INIT;
            level_q     <= '0;
            score_q     <= '0;
            pts_q       <= '0;
            banner_q    <= '0;
            btnu_prev_q <= 1'b0;
            btnc_prev_q <= 1'b0;
            btnu_arm_q  <= 1'b0;
            btnc_arm_q  <= 1'b0;
        end else begin
            btnu_prev_q <= BtnU;
            btnc_prev_q <= BtnC;
            btnu_arm_q  <= btnu_arm_q | ~BtnU;
            btnc_arm_q  <= btnc_arm_q | ~BtnC;
            case (state_q)
                S_INIT: begin
                    if (btnu_rise) begin
                        state_q  <= S_PLAY;
                        lives_q  <= LIVES_INIT;
                        level_q  <= '0;
                        score_q  <= '0;
                        pts_q    <= '0;
                        banner_q <= '0;
                    end
                end
                S_PLAY: begin
                    if (hit && lives_q == 4'd1) begin
                        lives_q <= '0;
                        state_q <= S_OVER;
                        if (score_inc) score_q <= score_sat;
                    end else begin
                        if (hit && lives_q > 4'd1) lives_q <= lives_q - 4'd1;
                        if (score_inc) begin
                            score_q <= score_sat;
                            pts_q   <= pts_wrap ? '0 : pts_q + PTS_W'(1);
                        end
                        // A level clear takes precedence over a pause request in the same cycle.
                        if (score_inc && pts_wrap)
                            state_q <= (level_q == LEVEL_LAST) ? S_WIN : S_LVLUP;
                        else if (btnc_rise)
                            state_q <= S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (btnu_rise || btnc_rise) state_q <= S_PLAY;
                end
                S_LVLUP: begin
                    if (banner_q == BAN_LAST) begin
                        banner_q <= '0;
                        state_q  <= S_PLAY;
                        if (level_q != LEVEL_LAST) level_q <= level_q + 4'd1;
                    end else begin
                        banner_q <= banner_q + BAN_W'(1);
                    end
                end
                S_OVER, S_WIN: begin
                    if (btnu_rise) begin
                        state_q  <= S_INIT;
                        lives_q  <= LIVES_INIT;
                        level_q  <= '0;
                        score_q  <= '0;
                        pts_q    <= '0;
                        banner_q <= '0;
                    end
                end
                default: begin
                    state_q  <= S_INIT;
                    lives_q  <= LIVES_INIT;
                    level_q  <= '0;
                    score_q  <= '0;
                    pts_q    <= '0;
                    banner_q <= '0;
                end
            endcase
        end
    end

    assign q_Init     = state_q[0];
    assign q_Play     = state_q[1];
    assign q_Pause    = state_q[2];
    assign q_LevelUp  = state_q[3];
    assign q_GameOver = state_q[4];
    assign q_Win      = state_q[5];
    assign play_flag  = state_q[1];
    assign lives      = lives_q;
    assign level      = level_q;
    assign score      = score_q;

endmodule

`default_nettype wire

// File: tb/tb_nexys_starship_game_ctrl.sv
// ==========================================================================
// tb_nexys_starship_game_ctrl: directed and randomized checks of the game controller
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_nexys_starship_game_ctrl;

    localparam int LIVES         = 3;
    localparam int LEVELS        = 2;
    localparam int LEVEL_PTS     = 4;
    localparam int SCORE_W       = 12;
    localparam int BANNER_CYCLES = 5;
    localparam int VW            = 15 + SCORE_W;

    localparam int ST_INIT = 0, ST_PLAY = 1, ST_PAUSE = 2, ST_LVL = 3, ST_OVER = 4, ST_WIN = 5;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic BtnU = 1'b0, BtnC = 1'b0, hit = 1'b0, score_inc = 1'b0;
    logic q_Init, q_Play, q_Pause, q_LevelUp, q_GameOver, q_Win, play_flag;
    logic [3:0] lives, level;
    logic [SCORE_W-1:0] score;

    nexys_starship_game_ctrl #(
        .LIVES(LIVES), .LEVELS(LEVELS), .LEVEL_PTS(LEVEL_PTS),
        .SCORE_W(SCORE_W), .BANNER_CYCLES(BANNER_CYCLES)
    ) dut (
        .Clk(Clk), .Reset(Reset), .BtnU(BtnU), .BtnC(BtnC), .hit(hit), .score_inc(score_inc),
        .q_Init(q_Init), .q_Play(q_Play), .q_Pause(q_Pause), .q_LevelUp(q_LevelUp),
        .q_GameOver(q_GameOver), .q_Win(q_Win), .play_flag(play_flag),
        .lives(lives), .level(level), .score(score)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int passes = 0;

    logic [VW-1:0] obs;
    assign obs = {q_Init, q_Play, q_Pause, q_LevelUp, q_GameOver, q_Win, play_flag, lives, level, score};

    // Reference model: game mode plus plain integer counters; banner tracked as cycles dwelt.
    int m_st, m_lives, m_level, m_score, m_pts, m_dwell;
    bit m_pu, m_pc;

    task automatic model_reset();
        m_st = ST_INIT; m_lives = LIVES; m_level = 0; m_score = 0; m_pts = 0; m_dwell = 0;
        m_pu = 1'b1; m_pc = 1'b1;
    endtask

    task automatic model_restart();
        m_lives = LIVES; m_level = 0; m_score = 0; m_pts = 0; m_dwell = 0;
    endtask

    task automatic model_step(input bit u, input bit c, input bit h, input bit s);
        bit ru, rc, moved;
        ru = u && !m_pu;
        rc = c && !m_pc;
        m_pu = u;
        m_pc = c;
        moved = 1'b0;
        case (m_st)
            ST_INIT: if (ru) begin m_st = ST_PLAY; model_restart(); end
            ST_PLAY: begin
                if (h && m_lives == 1) begin
                    m_lives = 0;
                    m_st = ST_OVER;
                    if (s && m_score < (1 << SCORE_W) - 1) m_score++;
                end else begin
                    if (h && m_lives > 1) m_lives--;
                    if (s) begin
                        if (m_score < (1 << SCORE_W) - 1) m_score++;
                        m_pts++;
                        if (m_pts == LEVEL_PTS) begin
                            m_pts = 0;
                            m_st = (m_level == LEVELS - 1) ? ST_WIN : ST_LVL;
                            m_dwell = 0;
                            moved = 1'b1;
                        end
                    end
                    if (rc && !moved) m_st = ST_PAUSE;
                end
            end
            ST_PAUSE: if (ru || rc) m_st = ST_PLAY;
            ST_LVL: begin
                m_dwell++;
                if (m_dwell == BANNER_CYCLES) begin
                    m_dwell = 0;
                    m_level++;
                    m_st = ST_PLAY;
                end
            end
            default: if (ru) begin m_st = ST_INIT; model_restart(); end
        endcase
    endtask

    function automatic logic [VW-1:0] exp_vec();
        return {m_st == ST_INIT, m_st == ST_PLAY, m_st == ST_PAUSE, m_st == ST_LVL,
                m_st == ST_OVER, m_st == ST_WIN, m_st == ST_PLAY,
                4'(m_lives), 4'(m_level), SCORE_W'(m_score)};
    endfunction

    task automatic tick(input bit u, input bit c, input bit h, input bit s);
        BtnU = u; BtnC = c; hit = h; score_inc = s;
        @(posedge Clk);
        model_step(u, c, h, s);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        checks++; if (obs !== exp_vec()) $display("FAIL reset_vec got=%h exp=%h", obs, exp_vec()); else passes++;
        checks++;
        if ({q_Init, play_flag, lives, level, score} !== {1'b1, 1'b0, 4'd3, 4'd0, 12'd0})
            $display("FAIL reset_vals init=%b play=%b lives=%0d level=%0d score=%0d", q_Init, play_flag, lives, level, score);
        else passes++;
        #6 Reset = 1'b0;
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        checks++; if (obs !== exp_vec()) $display("FAIL reset_idle got=%h exp=%h", obs, exp_vec()); else passes++;
    endtask

    task automatic test_start();
        for (int i = 0; i < 10; i++) begin
            tick(1, 0, 0, 0);
            checks++;
            if ({q_Play, play_flag, q_Init, lives, level, score} !== {1'b1, 1'b1, 1'b0, 4'd3, 4'd0, 12'd0})
                $display("FAIL start_hold cyc=%0d play=%b flag=%b lives=%0d score=%0d exp play=1 lives=3 score=0", i, q_Play, play_flag, lives, score);
            else passes++;
        end
        tick(0, 0, 0, 0);
        checks++; if (obs !== exp_vec()) $display("FAIL start_vec got=%h exp=%h", obs, exp_vec()); else passes++;
    endtask

    task automatic test_levelup();
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 1);
            checks++; if (obs !== exp_vec()) $display("FAIL lvl_pulse i=%0d got=%h exp=%h", i, obs, exp_vec()); else passes++;
            if (i < 3) tick(0, 0, 0, 0);
        end
        checks++;
        if ({q_LevelUp, score} !== {1'b1, 12'd4}) $display("FAIL lvl_enter lvlup=%b score=%0d exp 1/4", q_LevelUp, score); else passes++;
        for (int k = 1; k <= 5; k++) begin
            tick(0, k == 2, k == 1 || k == 3, k == 4);
            checks++; if (obs !== exp_vec()) $display("FAIL lvl_banner k=%0d got=%h exp=%h", k, obs, exp_vec()); else passes++;
            checks++;
            if (k < 5 && {q_LevelUp, lives, level, score} !== {1'b1, 4'd3, 4'd0, 12'd4})
                $display("FAIL lvl_dwell k=%0d lvlup=%b lives=%0d level=%0d score=%0d", k, q_LevelUp, lives, level, score);
            else if (k == 5 && {q_Play, lives, level, score} !== {1'b1, 4'd3, 4'd1, 12'd4})
                $display("FAIL lvl_exit play=%b lives=%0d level=%0d score=%0d exp 1/3/1/4", q_Play, lives, level, score);
            else passes++;
        end
    endtask

    task automatic test_pause();
        tick(0, 1, 0, 0);
        checks++; if ({q_Pause, play_flag} !== 2'b10) $display("FAIL pause_enter pause=%b flag=%b exp 1/0", q_Pause, play_flag); else passes++;
        tick(0, 0, 1, 1);
        tick(0, 0, 1, 0);
        tick(0, 0, 0, 1);
        checks++;
        if ({q_Pause, lives, score} !== {1'b1, 4'd3, 12'd4}) $display("FAIL pause_frozen pause=%b lives=%0d score=%0d exp 1/3/4", q_Pause, lives, score); else passes++;
        tick(0, 1, 0, 0);
        checks++; if ({q_Play, play_flag} !== 2'b11) $display("FAIL pause_exit play=%b flag=%b exp 1/1", q_Play, play_flag); else passes++;
        tick(0, 0, 0, 0);
        checks++; if (obs !== exp_vec()) $display("FAIL pause_vec got=%h exp=%h", obs, exp_vec()); else passes++;
    endtask

    task automatic test_win();
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 1);
            if (i < 3) tick(0, 0, 0, 0);
        end
        checks++;
        if ({q_Win, q_LevelUp, score, level} !== {1'b1, 1'b0, 12'd8, 4'd1}) $display("FAIL win_enter win=%b lvlup=%b score=%0d level=%0d exp 1/0/8/1", q_Win, q_LevelUp, score, level); else passes++;
        tick(0, 0, 1, 0);
        tick(0, 1, 0, 1);
        checks++;
        if ({q_Win, lives, score} !== {1'b1, 4'd3, 12'd8}) $display("FAIL win_hold win=%b lives=%0d score=%0d exp 1/3/8", q_Win, lives, score); else passes++;
        tick(1, 0, 0, 0);
        checks++;
        if ({q_Init, lives, level, score} !== {1'b1, 4'd3, 4'd0, 12'd0}) $display("FAIL win_restart init=%b lives=%0d level=%0d score=%0d", q_Init, lives, level, score); else passes++;
        tick(0, 0, 0, 0);
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        checks++; if (obs !== exp_vec()) $display("FAIL win_replay got=%h exp=%h", obs, exp_vec()); else passes++;
    endtask

    task automatic test_gameover();
        tick(0, 0, 1, 0);
        checks++; if (lives !== 4'd2) $display("FAIL go_hit1 lives=%0d exp 2", lives); else passes++;
        tick(0, 0, 0, 0);
        tick(0, 0, 1, 0);
        checks++; if (lives !== 4'd1) $display("FAIL go_hit2 lives=%0d exp 1", lives); else passes++;
        tick(0, 0, 0, 0);
        tick(0, 0, 1, 1);
        checks++;
        if ({q_GameOver, q_LevelUp, lives, score} !== {1'b1, 1'b0, 4'd0, 12'd1}) $display("FAIL go_enter over=%b lvlup=%b lives=%0d score=%0d exp 1/0/0/1", q_GameOver, q_LevelUp, lives, score); else passes++;
        tick(0, 1, 1, 0);
        tick(0, 0, 0, 0);
        checks++; if ({q_GameOver, lives} !== {1'b1, 4'd0}) $display("FAIL go_hold over=%b lives=%0d exp 1/0", q_GameOver, lives); else passes++;
        tick(1, 0, 0, 0);
        checks++;
        if ({q_Init, lives, score} !== {1'b1, 4'd3, 12'd0}) $display("FAIL go_restart init=%b lives=%0d score=%0d exp 1/3/0", q_Init, lives, score); else passes++;
        tick(0, 0, 0, 0);
        tick(1, 0, 0, 0);
        checks++; if (q_Play !== 1'b1) $display("FAIL go_replay play=%b exp 1", q_Play); else passes++;
        tick(0, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            tick($urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0);
            checks++; if (obs !== exp_vec()) $display("FAIL random i=%0d got=%h exp=%h", i, obs, exp_vec()); else passes++;
        end
    endtask

    task automatic test_back_to_back_async_reset();
        Reset = 1'b1;
        #2;
        model_reset();
        checks++; if (obs !== exp_vec()) $display("FAIL rst_mid got=%h exp=%h", obs, exp_vec()); else passes++;
        Reset = 1'b0;
        tick(0, 0, 0, 0);
        tick(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 1);
        tick(0, 1, 0, 1);
        checks++;
        if ({q_LevelUp, q_Pause, score} !== {1'b1, 1'b0, 12'd4}) $display("FAIL b2b_clear lvlup=%b pause=%b score=%0d exp 1/0/4", q_LevelUp, q_Pause, score); else passes++;
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        #3 Reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({q_Init, q_LevelUp, play_flag, lives, level, score} !== {1'b1, 1'b0, 1'b0, 4'd3, 4'd0, 12'd0})
            $display("FAIL async_rst init=%b lvlup=%b lives=%0d level=%0d score=%0d exp 1/0/3/0/0", q_Init, q_LevelUp, lives, level, score);
        else passes++;
        #2 Reset = 1'b0;
        for (int k = 0; k < BANNER_CYCLES + 2; k++) tick(0, 0, 0, 0);
        checks++; if (obs !== exp_vec()) $display("FAIL async_after got=%h exp=%h", obs, exp_vec()); else passes++;
    endtask

    initial begin
        test_reset();
        test_start();
        test_levelup();
        test_pause();
        test_win();
        test_gameover();
        test_random();
        test_back_to_back_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
